uart_tx_port: RTL and testbench
===============================

UART_TX_PORT -- requirements
Module: uart_tx_port

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning number of queued bytes (power of two, at least 2).
REQ-003 SHALL have port clk  input  1  meaning the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port resetE  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port wr_en  input  1  meaning the processor write strobe for this port (PortSel & MemWrite).
REQ-006 SHALL have port wr_data  input  8  meaning the byte to transmit (WriteData[7:0]).
REQ-007 SHALL have port ovf_clr  input  1  meaning a one-cycle pulse that clears the overflow flag.
REQ-008 SHALL have port tx  output  1  meaning the serial line; idle high.
REQ-009 SHALL have port status  output  8  meaning {4'b0, overflow, busy, full, empty}, readable through the processor read mux.

Function
REQ-010 SHALL buffer bytes in a FIFO_DEPTH-entry FIFO; a byte is accepted when wr_en=1 and (full=0, or a pop occurs in the same cycle).
REQ-011 SHALL drop the byte when wr_en=1, full=1 and no pop occurs; it SHALL then set overflow, which stays set (sticky).
REQ-012 SHALL clear overflow on ovf_clr=1; if a drop and ovf_clr occur in the same cycle, overflow SHALL end up 1.
REQ-013 SHALL use FSM states IDLE, START, DATA, STOP; busy=1 in every state except IDLE.
REQ-014 In IDLE with empty=0, the FSM SHALL pop the head byte into the shift register and enter START on the next edge.
REQ-015 tx SHALL be registered; a byte written into an empty FIFO while in IDLE at edge k SHALL drive tx=0 from edge k+1.
REQ-016 START SHALL drive tx=0 for CLKS_PER_BIT cycles.
REQ-017 DATA SHALL send 8 bits LSB first, each for CLKS_PER_BIT cycles, tracked by a 3-bit bit index.
REQ-018 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles.
REQ-019 At the end of STOP, the FSM SHALL pop and go directly to START if empty=0, otherwise go to IDLE, so back-to-back frames have no idle gap.
REQ-020 Each frame SHALL last exactly 10*CLKS_PER_BIT cycles.
REQ-021 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide and wrap to 0 at CLKS_PER_BIT-1.
REQ-022 FIFO read and write pointers SHALL be $clog2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
REQ-023 full SHALL be derived as MSBs differing with the remaining bits equal; empty SHALL be derived as the pointers being equal.
REQ-024 The status flags SHALL reflect registered state only, with no combinational path from wr_en to status.

Reset
REQ-025 On resetE=0, the block SHALL asynchronously force state=IDLE, tx=1, both pointers=0, overflow=0, baud counter=0, bit index=0 and shift register=0.
REQ-026 The resulting reset value of status SHALL be 8'h01 (empty set).
REQ-027 Reset mid-frame SHALL immediately return tx to 1 and discard all queued bytes; no partial frame SHALL resume after release.
REQ-028 The first write SHALL be accepted on the first rising edge after resetE deasserts.

Structure
REQ-029 A shared package uart_pkg SHALL hold the FSM state enum (IDLE, START, DATA, STOP) and the status bit-position constants (EMPTY=0, FULL=1, BUSY=2, OVF=3).
REQ-030 The FIFO SHALL be a separate sub-module, tx_fifo, parameterised by width and depth, exposing push, pop, din, dout, full and empty.
REQ-031 FIFO storage SHALL be a register array with no reset on the data entries; only the pointers are reset.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-032 Release reset and idle for 20 cycles -> tx=1 and status=8'h01 throughout.
REQ-033 Write 8'hA5 once -> tx=0 from the next edge, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop=1, busy drops after 40 cycles, status returns to 8'h01.
REQ-034 Write 8'h01, 8'h02, 8'h03 on consecutive cycles -> three contiguous 40-cycle frames with no idle gap; bytes sampled in order 01, 02, 03.
REQ-035 With the FSM in DATA, write 5 bytes -> full=1 after 4 bytes, the 5th byte is dropped, status bit 3 =1; an ovf_clr pulse then clears it.
REQ-036 With full=1, pulse wr_en in the same cycle STOP ends and a pop occurs -> the byte is accepted and full stays 1.
REQ-037 Assert resetE=0 at cycle 15 of a frame with 2 bytes queued -> tx=1 within the same cycle, status=8'h01, and no further frames are sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit port.
// FSM state encoding plus bit positions inside the status byte.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int EMPTY = 0;
  localparam int FULL  = 1;
  localparam int BUSY  = 2;
  localparam int OVF   = 3;

endpackage

// File: rtl/uart_tx_port_if.sv
// Processor-side bus of the UART transmit port.
// The processor is the master; the port itself is the slave.
interface uart_tx_port_if;
  import uart_pkg::*;

  logic       wr_en;
  logic [7:0] wr_data;
  logic       ovf_clr;
  logic       tx;
  logic [7:0] status;

  modport master (output wr_en, wr_data, ovf_clr, input tx, status);
  modport slave  (input wr_en, wr_data, ovf_clr, output tx, status);

endinterface

// File: rtl/tx_fifo.sv
// Small first-word-fall-through FIFO; a push into a full FIFO is
// accepted only when a pop frees the head slot on the same edge.
module tx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetE,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_reg;
  logic [AW:0]      rptr_reg;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wptr_reg == rptr_reg);
  assign full    = (wptr_reg[AW] != rptr_reg[AW]) &&
                   (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr_reg[AW-1:0]];

  always_ff @(posedge clk or negedge resetE) begin
    if (!resetE) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
    end else begin
      if (do_push) wptr_reg <= wptr_reg + 1'b1;
      if (do_pop)  rptr_reg <= rptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_reg[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped UART transmitter: byte FIFO feeding an 8N1 serialiser,
// with sticky overflow and a status byte for the processor read mux.
module uart_tx_port
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           resetE,
  uart_tx_port_if.slave  bus
);

  localparam int             BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_t     state_reg;
  logic          tx_reg;
  logic [BW-1:0] baud_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic          ovf_reg;

  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_dout;
  logic          baud_end;
  logic          pop;
  logic          drop;
  logic [7:0]    status_bits;

  assign baud_end = (baud_reg == BAUD_LAST);
  // Head byte leaves the FIFO on the same edge the frame (re)starts.
  assign pop  = !fifo_empty &&
                ((state_reg == IDLE) || ((state_reg == STOP) && baud_end));
  assign drop = bus.wr_en && fifo_full && !pop;

  tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetE (resetE),
    .push   (bus.wr_en),
    .pop    (pop),
    .din    (bus.wr_data),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk or negedge resetE) begin
    if (!resetE) begin
      state_reg   <= IDLE;
      tx_reg      <= 1'b1;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
    end else begin
      if (state_reg == IDLE) baud_reg <= '0;
      else                   baud_reg <= baud_end ? '0 : baud_reg + 1'b1;

      case (state_reg)
        IDLE: begin
          if (pop) begin
            shift_reg <= fifo_dout;
            tx_reg    <= 1'b0;
            state_reg <= START;
          end
        end
        START: begin
          if (baud_end) begin
            tx_reg      <= shift_reg[0];
            shift_reg   <= shift_reg >> 1;
            bit_idx_reg <= '0;
            state_reg   <= DATA;
          end
        end
        DATA: begin
          if (baud_end) begin
            bit_idx_reg <= bit_idx_reg + 1'b1;
            if (bit_idx_reg == 3'd7) begin
              tx_reg    <= 1'b1;
              state_reg <= STOP;
            end else begin
              tx_reg    <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end
        end
        STOP: begin
          if (baud_end) begin
            if (pop) begin
              shift_reg <= fifo_dout;
              tx_reg    <= 1'b0;
              state_reg <= START;
            end else begin
              tx_reg    <= 1'b1;
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // A drop wins over a simultaneous clear so no overflow is ever lost.
  always_ff @(posedge clk or negedge resetE) begin
    if (!resetE)           ovf_reg <= 1'b0;
    else if (drop)         ovf_reg <= 1'b1;
    else if (bus.ovf_clr)  ovf_reg <= 1'b0;
  end

  always_comb begin
    status_bits        = '0;
    status_bits[EMPTY] = fifo_empty;
    status_bits[FULL]  = fifo_full;
    status_bits[BUSY]  = (state_reg != IDLE);
    status_bits[OVF]   = ovf_reg;
  end

  assign bus.tx     = tx_reg;
  assign bus.status = status_bits;

endmodule

// File: tb/tb_uart_tx_port.sv
// Self-checking bench: directed and random writes compared each cycle
// against a frame-timing model built from queues and bit arithmetic.
module tb_uart_tx_port;
  import uart_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic resetE = 1'b0;
  int   total = 0;
  int   bad   = 0;

  uart_tx_port_if bus ();

  uart_tx_port #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk    (clk),
    .resetE (resetE),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference model: queued bytes plus the byte and start edge of the current frame.
  logic [7:0] q[$];
  logic       m_active;
  logic [7:0] m_cur;
  int         m_start;
  int         m_edge;
  logic       m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_tx();
    int pos;
    if (!m_active) return 1'b1;
    pos = (m_edge - m_start) / CPB;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return m_cur[pos-1];
    return 1'b1;
  endfunction

  function automatic logic [7:0] model_status();
    return {4'b0, m_ovf, m_active, (q.size() == DEPTH), (q.size() == 0)};
  endfunction

  function automatic logic model_pops_next();
    logic fend;
    fend = m_active && (m_edge + 1 - m_start == FRAME);
    return (q.size() > 0) && (!m_active || fend);
  endfunction

  task automatic model_reset();
    q.delete();
    m_active = 1'b0;
    m_cur    = '0;
    m_start  = 0;
    m_edge   = 0;
    m_ovf    = 1'b0;
  endtask

  task automatic model_edge(input logic we, input logic [7:0] d, input logic clr);
    logic fend, popn, was_full;
    m_edge++;
    fend     = m_active && (m_edge - m_start == FRAME);
    popn     = (q.size() > 0) && (!m_active || fend);
    was_full = (q.size() == DEPTH);
    if (popn) begin
      m_cur    = q.pop_front();
      m_start  = m_edge;
      m_active = 1'b1;
      $display("frame start byte=%02h edge=%0d", m_cur, m_edge);
    end else if (fend) begin
      m_active = 1'b0;
    end
    if (we) begin
      if (!was_full || popn) begin
        q.push_back(d);
        $display("write byte=%02h accepted depth=%0d", d, q.size());
      end else begin
        $display("write byte=%02h dropped", d);
      end
    end
    if (we && was_full && !popn) m_ovf = 1'b1;
    else if (clr)                m_ovf = 1'b0;
  endtask

  task automatic step(input logic we, input logic [7:0] d, input logic clr);
    bus.wr_en   = we;
    bus.wr_data = d;
    bus.ovf_clr = clr;
    @(posedge clk);
    model_edge(we, d, clr);
    #1;
    check("tx", bus.tx, model_tx());
    check("status", bus.status, model_status());
    bus.wr_en   = 1'b0;
    bus.ovf_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.ovf_clr = 1'b0;
    model_reset();

    #12;
    check("rst_tx", bus.tx, 1'b1);
    check("rst_status", bus.status, 8'h01);
    resetE = 1'b1;

    idle(20);

    step(1'b1, 8'hA5, 1'b0);
    idle(FRAME + 5);
    check("a5_done", bus.status, 8'h01);

    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    step(1'b1, 8'h03, 1'b0);
    idle(3 * FRAME + 5);

    // Overflow while the serialiser is mid-frame
    step(1'b1, 8'h11, 1'b0);
    idle(12);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'h20 + 8'(i), 1'b0);
      if (i == 3) check("full_after4", bus.status[FULL], 1'b1);
    end
    check("ovf_set", bus.status[OVF], 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check("ovf_clr", bus.status[OVF], 1'b0);
    idle(5 * FRAME + 5);

    // Write into a full FIFO on the very edge that pops the head
    for (int i = 0; i < 5; i++) step(1'b1, 8'h40 + 8'(i), 1'b0);
    check("full_before_pop", bus.status[FULL], 1'b1);
    for (int i = 0; i < 2 * FRAME && !model_pops_next(); i++) idle(1);
    check("pop_edge_found", model_pops_next(), 1'b1);
    step(1'b1, 8'h77, 1'b0);
    check("full_kept", bus.status[FULL], 1'b1);
    check("no_ovf_on_pop", bus.status[OVF], 1'b0);
    idle(6 * FRAME + 5);

    for (int i = 0; i < 800; i++)
      step(($urandom_range(0, 7) == 0), 8'($urandom), ($urandom_range(0, 59) == 0));
    idle(6 * FRAME + 5);

    // Reset during a frame with two bytes still queued
    step(1'b1, 8'hC3, 1'b0);
    step(1'b1, 8'h5A, 1'b0);
    step(1'b1, 8'h96, 1'b0);
    for (int i = 0; i < FRAME && (m_edge - m_start) < 14; i++) idle(1);
    #2;
    resetE = 1'b0;
    #1;
    check("midrst_tx", bus.tx, 1'b1);
    check("midrst_status", bus.status, 8'h01);
    @(posedge clk);
    #1;
    check("inrst_tx", bus.tx, 1'b1);
    resetE = 1'b1;
    model_reset();
    idle(3 * FRAME);

    // First edge after release must accept a write
    #2;
    resetE = 1'b0;
    #3;
    resetE = 1'b1;
    model_reset();
    step(1'b1, 8'h3C, 1'b0);
    check("first_wr_busy", bus.status[BUSY], 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check("first_wr_tx", bus.tx, 1'b0);
    idle(FRAME + 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
